// File: rtl/nibble_serial_reducer_if.sv
// Valid/ready operand stream in, reduced result out.
interface nibble_serial_reducer_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic               out_overflow;
  logic [COUNT_W-1:0] out_count;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, out_count
  );

  // Reducer side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, out_count
  );
endinterface

// File: rtl/nibble_serial_reducer.sv
// Serial reducer: sums an operand stream one nibble per cycle through a
// 4-bit carry-lookahead slice, carrying between nibbles in a register.

// 4-bit carry-lookahead adder slice.
module nibble_serial_reducer_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p, c;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries from generate/propagate terms
  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end
endmodule

module nibble_serial_reducer #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_reducer_if.slave bus
);
  localparam int NNIB  = WIDTH / 4;
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NNIB-1:0][3:0]   acc;
  logic [NNIB-1:0][3:0]   op;
  logic                   last;
  logic                   carry;
  logic [IDX_W-1:0]       idx;
  logic                   ovf;
  logic [COUNT_W-1:0]     cnt;
  logic [3:0]             nib_sum;
  logic                   nib_co;
  logic                   last_nib;

  assign last_nib = (idx == LAST_IDX);

  nibble_serial_reducer_cla4 u_cla (
    .a  (acc[idx]),
    .b  (op[idx]),
    .ci (carry),
    .s  (nib_sum),
    .co (nib_co)
  );

  assign bus.out_sum      = acc;
  assign bus.out_overflow = ovf;
  assign bus.out_count    = cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ADD;
      end
      ADD: begin
        if (last_nib) state_nxt = last ? DONE : IDLE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, nibble-serial accumulate, sticky overflow, count
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      op    <= '0;
      last  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op    <= bus.in_data;
          last  <= bus.in_last;
          idx   <= '0;
          carry <= 1'b0;
          if (cnt != '1) cnt <= cnt + 1'b1;
        end
        ADD: begin
          acc[idx] <= nib_sum;
          if (last_nib) begin
            // Carry out of the top nibble is the operand overflow
            ovf   <= ovf | nib_co;
            carry <= 1'b0;
            idx   <= '0;
          end else begin
            carry <= nib_co;
            idx   <= idx + 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          acc <= '0;
          ovf <= 1'b0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_reducer.md
Name: nibble_serial_reducer

Overview:
Sequential reduction stage that sums a stream of WIDTH-bit operands into one WIDTH-bit total. It sits directly upstream of the 4-bit carry-lookahead slice and feeds it one nibble pair plus a carry-in per cycle, registering the slice's carry-out for the next nibble. Upstream producers connect through a valid/ready input stream. The reduced result is presented on a valid/ready output with a sticky overflow flag and an operand count.

Parameters:
WIDTH, 16, operand and accumulator width in bits; must be a multiple of 4 and at least 4
COUNT_W, 8, width of the operand counter

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand present
in_ready  output  1  block can accept an operand this cycle
in_data  input  WIDTH  operand
in_last  input  1  operand is the final one of the current reduction
out_valid  output  1  reduction result available
out_ready  input  1  consumer accepts the result
out_sum  output  WIDTH  accumulated sum, modulo 2^WIDTH
out_overflow  output  1  sticky: at least one add produced a carry out of bit WIDTH-1
out_count  output  COUNT_W  operands accumulated, saturating at 2^COUNT_W-1

Behaviour:
- Reset (rst=1 at an edge): state IDLE, accumulator=0, carry=0, nibble index=0, overflow=0, count=0, latched operand/last=0. Outputs: in_ready=1, out_valid=0, out_sum=0, out_overflow=0, out_count=0. Reset overrides any in-flight operation, including ADD and DONE.
- NNIB = WIDTH/4.
- IDLE: in_ready=1.
  - On in_valid && in_ready, latch in_data and in_last, then go to ADD with nibble index=0 and carry=0.
  - Count increments at accept, saturating.
- ADD: in_ready=0, out_valid=0. Each cycle, nibble k of the accumulator plus nibble k of the operand plus carry goes through a 4-bit add.
  - The result overwrites accumulator nibble k, carry takes the slice carry-out, and k increments.
  - On the cycle with k=NNIB-1, the carry-out is ORed into overflow and carry clears.
  - Next state is DONE if the latched last=1, else IDLE.
  - ADD always lasts exactly NNIB cycles. Inputs are ignored throughout.
- DONE: out_valid=1, in_ready=0. out_sum, out_overflow and out_count stay stable while out_ready=0.
  - On out_valid && out_ready, accumulator, overflow and count clear to 0 and the state returns to IDLE.
- Output timing: out_sum, out_overflow and out_count are direct register outputs, visible in every state. Only in DONE are they qualified by out_valid.
- Timing: operand accepted in cycle 0; ADD occupies cycles 1..NNIB; the next accept or out_valid comes in cycle NNIB+1. Throughput is one operand per NNIB+1 cycles.
- Arithmetic: unsigned, wraps modulo 2^WIDTH. Overflow is sticky across all operands of one reduction.
- A reduction of a single operand with in_last=1 is legal. There is no empty-reduction case: a reduction is always at least one operand.
- A reset asserted in the same cycle as an input or output handshake wins; the handshake is discarded.

Test Plan:
1. WIDTH=16, accept 0x1234 with in_last=1 in cycle 0 -> out_valid first high in cycle 5, out_sum=0x1234, out_overflow=0, out_count=1; in_ready=0 in cycles 1-5.
2. Operands 0x0FFF then 0x0001 (last) -> carry ripples across nibbles; out_sum=0x1000, out_overflow=0, out_count=2.
3. Operands 0xFFFF then 0x0002 (last) -> out_sum=0x0001, out_overflow=1, out_count=2. Follow with a new reduction of 0x0003 (last) -> out_sum=0x0003, out_overflow=0, out_count=1.
4. Hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_sum/overflow/count unchanged, in_ready=0 and in_valid ignored. Then assert out_ready for 1 cycle -> next cycle in_ready=1, out_valid=0, out_sum=0.
5. Accept 0xABCD, assert rst during the 2nd ADD cycle -> next cycle all outputs at reset values and in_ready=1. Then 0x0005 (last) -> out_sum=0x0005, out_count=1.
6. COUNT_W=2: five operands of 0x0001, the last with in_last=1, with in_valid gaps between them -> out_sum=0x0005, out_count=3 (saturated), out_overflow=0.
